// File: rtl/iq_stream_packer.sv
// ============================================================================
// iq_stream_packer
// ----------------------------------------------------------------------------
// Packs 12-bit I/Q sample pairs from the RF receive path into 32-bit words
// for the AXI stream-to-OCM bridge. All logic runs in the Sclk domain.
//
// Packing modes (latched when capture starts):
//   mode 0 : one pair per word  -> {sext16(Q), sext16(I)}
//   mode 1 : two pairs per word -> {Q1[11:4], I1[11:4], Q0[11:4], I0[11:4]}
//
// Ports:
//   Sclk       in   sample clock, rising edge
//   rst        in   asynchronous reset, active low
//   enable     in   capture enable (level)
//   mode       in   packing mode, sampled on capture start only
//   rx_valid   in   rx_i / rx_q carry a new sample this cycle
//   rx_i       in   12-bit I sample, two's complement
//   rx_q       in   12-bit Q sample, two's complement
//   Sdata      out  packed word, held until the next Sen
//   Sen        out  one-cycle strobe per completed word
//   sync       out  one-cycle marker on the first word of each frame
//   word_cnt   out  words emitted since the last capture start
//   frame_cnt  out  frames started since the last capture start
//   active     out  capture state machine is in RUN
// ============================================================================
module iq_stream_packer #(
    parameter int FRAME_WORDS = 16384,
    parameter int CNT_W       = 32
) (
    input  logic             Sclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             rx_valid,
    input  logic [11:0]      rx_i,
    input  logic [11:0]      rx_q,
    output logic [31:0]      Sdata,
    output logic             Sen,
    output logic             sync,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             active
);

    // FRAME_WORDS is a power of two, so the index simply overflows to 0
    // at the end of each frame.
    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               half_q, half_d;
    logic [15:0]        hold_q, hold_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        sdata_q, sdata_d;
    logic               sen_q, sen_d;
    logic               sync_q, sync_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               emit;
    logic [31:0]        word_v;

    // State and datapath registers. Reset drops any half-built word and
    // returns everything to an all-zero, idle condition.
    always_ff @(posedge Sclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            half_q      <= 1'b0;
            hold_q      <= '0;
            idx_q       <= '0;
            sdata_q     <= '0;
            sen_q       <= 1'b0;
            sync_q      <= 1'b0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            half_q      <= half_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            sdata_q     <= sdata_d;
            sen_q       <= sen_d;
            sync_q      <= sync_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic. A word is only emitted while enable stays high;
    // when enable falls, the cycle's sample (and any held half word) is
    // thrown away so that a stopped capture never produces a partial frame.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        half_d      = half_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        sdata_d     = sdata_q;
        sen_d       = 1'b0;
        sync_d      = 1'b0;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        emit        = 1'b0;
        word_v      = '0;

        case (state_q)
            IDLE: begin
                // Samples arriving on the start cycle are ignored on purpose:
                // capture begins with the next valid sample.
                if (enable) begin
                    state_d     = RUN;
                    mode_d      = mode;
                    half_d      = 1'b0;
                    hold_d      = '0;
                    idx_d       = '0;
                    word_cnt_d  = '0;
                    frame_cnt_d = '0;
                end
            end

            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    half_d  = 1'b0;
                    hold_d  = '0;
                end else if (rx_valid) begin
                    if (!mode_q) begin
                        emit   = 1'b1;
                        word_v = {{4{rx_q[11]}}, rx_q, {4{rx_i[11]}}, rx_i};
                    end else if (!half_q) begin
                        // Keep only the top byte of each component; the low
                        // nibble is truncated, never rounded.
                        hold_d = {rx_q[11:4], rx_i[11:4]};
                        half_d = 1'b1;
                    end else begin
                        emit   = 1'b1;
                        word_v = {rx_q[11:4], rx_i[11:4], hold_q};
                        half_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Every emitted word advances the frame index; index 0 opens a frame.
        if (emit) begin
            sdata_d    = word_v;
            sen_d      = 1'b1;
            sync_d     = (idx_q == '0);
            idx_d      = idx_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            if (idx_q == '0) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    assign Sdata     = sdata_q;
    assign Sen       = sen_q;
    assign sync      = sync_q;
    assign word_cnt  = word_cnt_q;
    assign frame_cnt = frame_cnt_q;
    assign active    = (state_q == RUN);

endmodule

// File: doc/iq_stream_packer.md
# iq_stream_packer

Upstream feeder of the AXI stream-to-OCM bridge in the Sclk domain. Takes 12-bit I/Q sample pairs from the RF front-end receive path and packs them into 32-bit words. Emits one write strobe per completed word, and a one-cycle `sync` that marks the first word of every OCM frame. `Sdata`, `Sen` and `sync` connect directly to the bridge's `Sin`, `Ien` and `sync`.

## Interface
- `FRAME_WORDS`, default 16384: words per OCM frame (64 KB window); power of two, ≥ 2.
- `CNT_W`, default 32: width of the status counters.

Ports:
- `Sclk`  in  1  sample clock; sole clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable; level.
- `mode`  in  1  packing mode: 0 = 16-bit (1 pair/word), 1 = 8-bit (2 pairs/word).
- `rx_valid`  in  1  `rx_i`/`rx_q` carry a new sample this cycle.
- `rx_i`  in  12  I sample, two's complement.
- `rx_q`  in  12  Q sample, two's complement.
- `Sdata`  out  32  packed word.
- `Sen`  out  1  `Sdata` valid this cycle; single-cycle strobe.
- `sync`  out  1  first word of a frame; coincident with `Sen`.
- `word_cnt`  out  CNT_W  words emitted since the last capture start.
- `frame_cnt`  out  CNT_W  frames started since the last capture start.
- `active`  out  1  state is RUN.

## Operation
- States:
  - IDLE: waits for `enable`=1.
  - RUN: captures samples.
- Transitions:
  - IDLE→RUN on `enable`=1. `mode` is latched into `mode_r` on this edge; `mode` is ignored while in RUN.
  - Entering RUN clears `word_cnt`, `frame_cnt`, the intra-frame word index and the half-word flag.
  - RUN→IDLE on `enable`=0. A pending half word (mode 1, one pair held) is discarded and no `Sen` is issued. A word completing in the same cycle that `enable` falls is also discarded.
- Mode 0 packing, per valid sample: `Sdata` = {sext16(`rx_q`), sext16(`rx_i`)}; one word per sample.
- Mode 1 packing:
  - First valid sample: I0 = `rx_i[11:4]`, Q0 = `rx_q[11:4]` are held internally. Truncation only, no rounding.
  - Second valid sample: `Sdata` = {Q1[11:4], I1[11:4], Q0, I0}.
- Frame index:
  - Counts 0..FRAME_WORDS-1 per emitted word and wraps to 0.
  - `sync`=1 exactly when a word with index 0 is emitted. This includes the first word after every IDLE→RUN.
  - `frame_cnt` increments on each `sync`.
- `word_cnt` increments on each `Sen`. Both counters wrap modulo 2^CNT_W.
- `rx_valid` while in IDLE is ignored. `rx_valid` on the same cycle as IDLE→RUN is also ignored; the first captured sample is the next valid one.
- There is no backpressure: the downstream bridge accepts every `Sen`.

## Timing
- All outputs are registered.
- Latency from the completing `rx_valid` edge to `Sen`=1:
  - mode 0: 1 cycle.
  - mode 1: 1 cycle after the second sample.
- `Sen` and `sync` are high for exactly one cycle per word. `Sdata` holds its value until the next `Sen`.
- Back-to-back `rx_valid`:
  - mode 0: `Sen` every cycle.
  - mode 1: `Sen` every other cycle.
- `word_cnt` and `frame_cnt` update in the same cycle as the `Sen`/`sync` they count.
- `active` rises 1 cycle after `enable` rises and falls 1 cycle after `enable` falls.
- Reset (`rst`=0, asynchronous):
  - State = IDLE.
  - `Sdata`=0, `Sen`=0, `sync`=0, `word_cnt`=0, `frame_cnt`=0, `active`=0.
  - Half-word flag and frame index cleared.
- Reset asserted mid-word drops the pending data.
- After release, no `Sen` is issued until a new IDLE→RUN.

## Test plan
- **Reset values:** assert `rst`=0 mid-RUN with mode 1 and one pair pending -> all outputs are 0 immediately. After release, 10 `rx_valid` cycles with `enable`=0 produce no `Sen`.
- **Mode 0 packing:** `rx_i`=12'h800, `rx_q`=12'h7FF, one valid cycle -> 1 cycle later `Sdata`=32'h07FF_F800, `Sen`=1, `sync`=1, `word_cnt`=1.
- **Mode 1 packing:**
  - Stimulus: pair (I=12'h123, Q=12'h456), then pair (I=12'hABC, Q=12'hDEF).
  - Required: one `Sen` with `Sdata`=32'hDEAB_4512. No `Sen` after the first pair.
- **Frame wrap:** set FRAME_WORDS=4 and run 9 words in mode 0 -> `sync` on words 0, 4 and 8; `frame_cnt`=3; `word_cnt`=9.
- **Disable mid-word:** in mode 1, send one pair, then drop `enable` -> no `Sen`. Re-enable in mode 0 -> the first word carries `sync`=1 and `word_cnt` restarts at 1.
- **Mode latch:** toggle `mode` during RUN with continuous `rx_valid` -> the packing format and the `Sen` rate stay at the latched mode.
